multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the MIPS datapath around the instruction decoder.
- Consumes decoder fields (op, funct, rt, type flags, link flag), the ALU branch-compare result and memory ready handshakes.
- Drives fetch, PC update, register-file write and data-memory control, one instruction at a time.
- Replaces single-cycle control in the multi-cycle core variant.

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/multicycle_ctrl_instr_classifier.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE  = 3'd0,
        CL_JR     = 3'd1,
        CL_JALR   = 3'd2,
        CL_LOAD   = 3'd3,
        CL_STORE  = 3'd4,
        CL_BRANCH = 3'd5,
        CL_JUMP   = 3'd6,
        CL_IALU   = 3'd7
    } instr_class_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] WSEL_RD  = 2'd0;
    localparam logic [1:0] WSEL_RT  = 2'd1;
    localparam logic [1:0] WSEL_R31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_instr_classifier.sv
// rtl/multicycle_ctrl_instr_classifier.sv - combinational op/funct/rt to instruction class
module instr_classifier
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output logic [2:0] instr_class,
    output logic       illegal
);

    always_comb begin
        instr_class = CL_RTYPE;
        illegal     = 1'b0;
        case (op)
            OP_SPECIAL: begin
                if (funct == FN_JR)
                    instr_class = CL_JR;
                else if (funct == FN_JALR)
                    instr_class = CL_JALR;
                else
                    instr_class = CL_RTYPE;
            end
            OP_REGIMM: begin
                instr_class = CL_BRANCH;
                illegal = !((rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                            (rt == RT_BLTZAL) || (rt == RT_BGEZAL));
            end
            OP_J, OP_JAL:
                instr_class = CL_JUMP;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                instr_class = CL_LOAD;
            OP_SB, OP_SH, OP_SW:
                instr_class = CL_STORE;
            default: begin
                if (op >= OP_BEQ && op <= OP_BGTZ)
                    instr_class = CL_BRANCH;
                else if (op >= OP_ADDI && op <= OP_LUI)
                    instr_class = CL_IALU;
                else
                    illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM; MULTICYCLE_CTRL_PERF_CNT_EN adds perf counters
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         PERF_CNT_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_dec_i,
    input  logic [5:0] funct_dec_i,
    input  logic [4:0] rt_dec_i,
    input  logic       use_link_reg_i,
    input  logic       branch_taken_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    output logic       imem_req_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       sign_ext_o,
    output logic       dmem_req_o,
    output logic       dmem_we_o,
    output logic       rf_we_o,
    output logic [1:0] rf_wsel_o,
    output logic [1:0] wb_src_o,
    output logic       illegal_instr_o,
    output logic       instr_retired_o,
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    output logic [PERF_CNT_W-1:0] cycle_cnt_o,
    output logic [PERF_CNT_W-1:0] instr_cnt_o,
`endif
    output logic [2:0] state_o
);

    state_t       state_q, state_d;
    instr_class_t class_q;
    logic         link_q;
    logic         zext_q;
    logic         illegal_q;

    logic [2:0]   cls_raw;
    logic         cls_illegal;

    logic         imem_req, ir_we, pc_we, sign_ext, dmem_req, dmem_we, rf_we, retired;
    logic [1:0]   pc_src, rf_wsel, wb_src;

    instr_classifier u_classifier (
        .op          (op_dec_i),
        .funct       (funct_dec_i),
        .rt          (rt_dec_i),
        .instr_class (cls_raw),
        .illegal     (cls_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= state_t'(RESET_STATE);
            class_q   <= CL_RTYPE;
            link_q    <= 1'b0;
            zext_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                class_q <= instr_class_t'(cls_raw);
                link_q  <= use_link_reg_i;
                zext_q  <= is_zero_ext(op_dec_i);
            end
            if (state_d == ST_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_SEQ;
        sign_ext = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = WSEL_RD;
        wb_src   = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // The class is not latched yet, so decode from the live IR fields.
                sign_ext = !is_zero_ext(op_dec_i);
                state_d  = cls_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                sign_ext = !zext_q;
                case (class_q)
                    CL_BRANCH: begin
                        pc_we  = branch_taken_i;
                        pc_src = PC_SRC_BRANCH;
                    end
                    CL_JUMP: begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_JUMP;
                    end
                    CL_JR, CL_JALR: begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_RS;
                    end
                    default: ;
                endcase
                if (class_q == CL_LOAD || class_q == CL_STORE)
                    state_d = ST_MEM;
                else if (class_q == CL_RTYPE || class_q == CL_IALU || link_q)
                    state_d = ST_WB;
                else
                    state_d = ST_FETCH;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == CL_STORE);
                if (dmem_ready_i)
                    state_d = (class_q == CL_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                rf_we   = 1'b1;
                state_d = ST_FETCH;
                case (class_q)
                    CL_RTYPE: begin
                        rf_wsel = WSEL_RD;
                        wb_src  = WB_ALU;
                    end
                    CL_IALU: begin
                        rf_wsel = WSEL_RT;
                        wb_src  = WB_ALU;
                    end
                    CL_LOAD: begin
                        rf_wsel = WSEL_RT;
                        wb_src  = WB_MEM;
                    end
                    default: begin
                        // Link write: JALR targets rd, JAL and BxxZAL target r31.
                        rf_wsel = (class_q == CL_JALR) ? WSEL_RD : WSEL_R31;
                        wb_src  = WB_PC;
                    end
                endcase
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    assign retired = (state_q != ST_FETCH) && (state_d == ST_FETCH);

    // Outputs are forced low while reset is held, even though FETCH would request.
    assign imem_req_o      = imem_req  & ~reset;
    assign ir_we_o         = ir_we     & ~reset;
    assign pc_we_o         = pc_we     & ~reset;
    assign pc_src_o        = reset ? 2'd0 : pc_src;
    assign sign_ext_o      = sign_ext  & ~reset;
    assign dmem_req_o      = dmem_req  & ~reset;
    assign dmem_we_o       = dmem_we   & ~reset;
    assign rf_we_o         = rf_we     & ~reset;
    assign rf_wsel_o       = reset ? 2'd0 : rf_wsel;
    assign wb_src_o        = reset ? 2'd0 : wb_src;
    assign illegal_instr_o = illegal_q & ~reset;
    assign instr_retired_o = retired   & ~reset;
    assign state_o         = reset ? 3'd0 : state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (retired)
                instr_cnt_o <= instr_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_dec_i, funct_dec_i;
    logic [4:0] rt_dec_i;
    logic       use_link_reg_i, branch_taken_i, imem_ready_i, dmem_ready_i;
    logic       imem_req_o, ir_we_o, pc_we_o, sign_ext_o, dmem_req_o, dmem_we_o, rf_we_o;
    logic [1:0] pc_src_o, rf_wsel_o, wb_src_o;
    logic       illegal_instr_o, instr_retired_o;
    logic [2:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instr_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .op_dec_i        (op_dec_i),
        .funct_dec_i     (funct_dec_i),
        .rt_dec_i        (rt_dec_i),
        .use_link_reg_i  (use_link_reg_i),
        .branch_taken_i  (branch_taken_i),
        .imem_ready_i    (imem_ready_i),
        .dmem_ready_i    (dmem_ready_i),
        .imem_req_o      (imem_req_o),
        .ir_we_o         (ir_we_o),
        .pc_we_o         (pc_we_o),
        .pc_src_o        (pc_src_o),
        .sign_ext_o      (sign_ext_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .rf_we_o         (rf_we_o),
        .rf_wsel_o       (rf_wsel_o),
        .wb_src_o        (wb_src_o),
        .illegal_instr_o (illegal_instr_o),
        .instr_retired_o (instr_retired_o),
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
        .cycle_cnt_o     (cycle_cnt_o),
        .instr_cnt_o     (instr_cnt_o),
`endif
        .state_o         (state_o)
    );

    // {imem_req, ir_we, pc_we, pc_src, sign_ext, dmem_req, dmem_we, rf_we, wsel, wb_src, illegal, retired, state}
    logic [17:0] outs;
    assign outs = {imem_req_o, ir_we_o, pc_we_o, pc_src_o, sign_ext_o, dmem_req_o, dmem_we_o,
                   rf_we_o, rf_wsel_o, wb_src_o, illegal_instr_o, instr_retired_o, state_o};

    function automatic logic [17:0] ev(input logic im, ir, pw, input logic [1:0] ps,
                                       input logic sx, dr, dw, rw, input logic [1:0] ws, wb,
                                       input logic il, rt, input logic [2:0] st);
        return {im, ir, pw, ps, sx, dr, dw, rw, ws, wb, il, rt, st};
    endfunction

    function automatic logic [17:0] ev_fetch_go();
        return ev(1,1,1,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd0);
    endfunction

    function automatic logic [17:0] ev_decode(input logic sx);
        return ev(0,0,0,2'd0,sx,0,0,0,2'd0,2'd0,0,0,3'd1);
    endfunction

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] rt, input logic link);
        op_dec_i = op; funct_dec_i = fn; rt_dec_i = rt; use_link_reg_i = link;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        imem_ready_i = 1'b1; dmem_ready_i = 1'b1; branch_taken_i = 1'b0;
        set_instr(6'h00, 6'h21, 5'h00, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 18'd0);
        end
        @(negedge clk);
        reset = 1'b0; imem_ready_i = 1'b0;
    endtask

    task automatic test_addu;
        logic [17:0] exp [4];
        exp[0] = ev_fetch_go();
        exp[1] = ev_decode(1);
        exp[2] = ev(0,0,0,2'd0,1,0,0,0,2'd0,2'd0,0,0,3'd2);
        exp[3] = ev(0,0,0,2'd0,0,0,0,1,2'd0,2'd0,0,1,3'd4);
        set_instr(6'h00, 6'h21, 5'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++;
                $display("FAIL addu cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_addi_fetch_wait;
        logic [17:0] exp [5];
        exp[0] = ev(1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd0);
        exp[1] = ev_fetch_go();
        exp[2] = ev_decode(1);
        exp[3] = ev(0,0,0,2'd0,1,0,0,0,2'd0,2'd0,0,0,3'd2);
        exp[4] = ev(0,0,0,2'd0,0,0,0,1,2'd1,2'd0,0,1,3'd4);
        set_instr(6'h08, 6'h00, 5'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_ready_i = (i != 0); dmem_ready_i = 1'b1;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++;
                $display("FAIL addi cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_lw_wait;
        logic [17:0] exp [7];
        exp[0] = ev_fetch_go();
        exp[1] = ev_decode(1);
        exp[2] = ev(0,0,0,2'd0,1,0,0,0,2'd0,2'd0,0,0,3'd2);
        exp[3] = ev(0,0,0,2'd0,0,1,0,0,2'd0,2'd0,0,0,3'd3);
        exp[4] = exp[3];
        exp[5] = exp[3];
        exp[6] = ev(0,0,0,2'd0,0,0,0,1,2'd1,2'd1,0,1,3'd4);
        set_instr(6'h23, 6'h00, 5'h00, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            imem_ready_i = 1'b1; dmem_ready_i = !(i == 3 || i == 4);
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++;
                $display("FAIL lw cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_sw;
        logic [17:0] exp [4];
        exp[0] = ev_fetch_go();
        exp[1] = ev_decode(1);
        exp[2] = ev(0,0,0,2'd0,1,0,0,0,2'd0,2'd0,0,0,3'd2);
        exp[3] = ev(0,0,0,2'd0,0,1,1,0,2'd0,2'd0,0,1,3'd3);
        set_instr(6'h2B, 6'h00, 5'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++;
                $display("FAIL sw cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_beq;
        logic [17:0] exp [3];
        for (int t = 0; t < 2; t++) begin
            exp[0] = ev_fetch_go();
            exp[1] = ev_decode(1);
            exp[2] = ev(0,0,(t == 1),2'd1,1,0,0,0,2'd0,2'd0,0,1,3'd2);
            set_instr(6'h04, 6'h00, 5'h00, 1'b0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                imem_ready_i = 1'b1; dmem_ready_i = 1'b1; branch_taken_i = (t == 1);
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    failures++;
                    $display("FAIL beq taken=%0d cycle %0d: got %h expected %h", t, i, outs, exp[i]);
                end
            end
        end
        branch_taken_i = 1'b0;
    endtask

    task automatic test_bltzal;
        logic [17:0] exp [4];
        exp[0] = ev_fetch_go();
        exp[1] = ev_decode(1);
        exp[2] = ev(0,0,0,2'd1,1,0,0,0,2'd0,2'd0,0,0,3'd2);
        exp[3] = ev(0,0,0,2'd0,0,0,0,1,2'd2,2'd2,0,1,3'd4);
        set_instr(6'h01, 6'h00, 5'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ready_i = 1'b1; branch_taken_i = 1'b0;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++;
                $display("FAIL bltzal cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_jal_jalr;
        logic [17:0] exp [4];
        for (int t = 0; t < 2; t++) begin
            exp[0] = ev_fetch_go();
            exp[1] = ev_decode(1);
            exp[2] = ev(0,0,1,(t == 0) ? 2'd2 : 2'd3,1,0,0,0,2'd0,2'd0,0,0,3'd2);
            exp[3] = ev(0,0,0,2'd0,0,0,0,1,(t == 0) ? 2'd2 : 2'd0,2'd2,0,1,3'd4);
            if (t == 0) set_instr(6'h03, 6'h00, 5'h00, 1'b1);
            else        set_instr(6'h00, 6'h09, 5'h00, 1'b1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                imem_ready_i = 1'b1;
                #1;
                checks++;
                if (outs !== exp[i]) begin
                    failures++;
                    $display("FAIL %s cycle %0d: got %h expected %h", (t == 0) ? "jal" : "jalr", i, outs, exp[i]);
                end
            end
        end
        use_link_reg_i = 1'b0;
    endtask

    task automatic test_trap;
        logic [17:0] exp_trap;
        exp_trap = ev(0,0,0,2'd0,0,0,0,0,2'd0,2'd0,1,0,3'd5);
        set_instr(6'h3F, 6'h00, 5'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            imem_ready_i = 1'b1;
            #1;
            checks++;
            if (i == 0 && outs !== ev_fetch_go()) begin
                failures++;
                $display("FAIL trap fetch: got %h expected %h", outs, ev_fetch_go());
            end else if (i == 1 && outs !== ev_decode(1)) begin
                failures++;
                $display("FAIL trap decode: got %h expected %h", outs, ev_decode(1));
            end else if (i >= 2 && outs !== exp_trap) begin
                failures++;
                $display("FAIL trap hold cycle %0d: got %h expected %h", i, outs, exp_trap);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== 18'd0) begin
            failures++;
            $display("FAIL trap reset: got %h expected %h", outs, 18'd0);
        end
        @(negedge clk);
        reset = 1'b0; imem_ready_i = 1'b0;
        #1;
        checks++;
        if (outs !== ev(1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd0)) begin
            failures++;
            $display("FAIL trap resume: got %h expected %h", outs, ev(1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd0));
        end
    endtask

    task automatic test_ori_reset_exec;
        logic [17:0] exp [3];
        exp[0] = ev_fetch_go();
        exp[1] = ev_decode(0);
        exp[2] = ev(0,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd2);
        set_instr(6'h0D, 6'h00, 5'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ready_i = 1'b1;
            #1;
            checks++;
            if (outs !== exp[i]) begin
                failures++;
                $display("FAIL ori cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (outs !== 18'd0) begin
            failures++;
            $display("FAIL ori reset_in_exec: got %h expected %h", outs, 18'd0);
        end
        @(negedge clk);
        reset = 1'b0; imem_ready_i = 1'b0;
        #1;
        checks++;
        if (outs !== ev(1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd0)) begin
            failures++;
            $display("FAIL ori resume: got %h expected %h", outs, ev(1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0,3'd0));
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_addi_fetch_wait();
        test_lw_wait();
        test_sw();
        test_beq();
        test_bltzal();
        test_jal_jalr();
        test_trap();
        test_ori_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
